// File: rtl/fp_mult_param.sv
// fp_mult_param: sequential floating-point multiplier with round-to-nearest-even and IEEE flags
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request, sampled only while idle
//   A, B       operands {sign, exp, frac}, captured on the accepting edge
//   C          result, held until the next done
//   busy       high from acceptance until the edge that raises done
//   done       one-cycle pulse marking a valid result and flags
//   overflow, underflow, invalid, inexact   exception flags, updated with done
module fp_mult_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    output logic [EXP_W+MAN_W:0]   C,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid,
    output logic                   inexact
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int N    = MAN_W + 1;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(N + 1);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, EXC} state_t;

    state_t                 state;
    logic [W-1:0]           a, b;
    logic                   sign;
    logic signed [EW-1:0]   e;
    logic [2*N-1:0]         p;
    logic [N-1:0]           mq;
    logic [CW-1:0]          cnt;
    logic [MAN_W-1:0]       frac;
    logic                   g, s;

    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [N:0]             sum;
    logic                   inc;
    logic [MAN_W:0]         rsum;
    logic signed [EW-1:0]   e_r;

    always_comb begin
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        a_zero = ea == '0;
        b_zero = eb == '0;
        a_inf  = &ea && fa == '0;
        b_inf  = &eb && fb == '0;
        a_nan  = &ea && fa != '0;
        b_nan  = &eb && fb != '0;
        sum    = {1'b0, p[2*N-1:N]} + (mq[0] ? {2'b01, fa} : '0);
        inc    = g & (s | frac[0]);
        // The hidden bit is always 1 here, so a carry out of the fraction
        // means the significand rolled over to 10.0: fraction becomes 0, e+1.
        rsum   = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        e_r    = e + $signed({{(EW-1){1'b0}}, rsum[MAN_W]});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            sign      <= 1'b0;
            e         <= '0;
            p         <= '0;
            mq        <= '0;
            cnt       <= '0;
            frac      <= '0;
            g         <= 1'b0;
            s         <= 1'b0;
            C         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a     <= A;
                    b     <= B;
                    busy  <= 1'b1;
                    state <= UNPACK;
                end
                UNPACK: begin
                    sign  <= a[W-1] ^ b[W-1];
                    e     <= EW'({2'b00, ea}) + EW'({2'b00, eb}) - EW'(BIAS);
                    p     <= '0;
                    mq    <= {1'b1, fb};
                    cnt   <= '0;
                    state <= (a_zero || b_zero || &ea || &eb) ? EXC : MULT;
                end
                MULT: begin
                    p     <= {sum, p[N-1:1]};
                    mq    <= mq >> 1;
                    cnt   <= cnt + CW'(1);
                    state <= cnt == CW'(MAN_W) ? NORM : MULT;
                end
                NORM: begin
                    frac  <= p[2*N-1] ? p[2*N-2:N] : p[2*N-3:N-1];
                    g     <= p[2*N-1] ? p[N-1] : p[N-2];
                    s     <= p[2*N-1] ? |p[N-2:0] : |p[N-3:0];
                    e     <= p[2*N-1] ? e + EW'(1) : e;
                    state <= ROUND;
                end
                ROUND: begin
                    overflow  <= e_r >= EMAX;
                    underflow <= e_r < EMAX && e_r <= 0;
                    invalid   <= 1'b0;
                    inexact   <= g | s | e_r >= EMAX | e_r <= 0;
                    C         <= e_r >= EMAX ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                 e_r <= 0    ? {sign, {(W-1){1'b0}}} :
                                               {sign, e_r[EXP_W-1:0], rsum[MAN_W-1:0]};
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                EXC: begin
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    inexact   <= 1'b0;
                    invalid   <= !(a_nan || b_nan) && ((a_inf && b_zero) || (b_inf && a_zero));
                    C         <= (a_nan || b_nan) || (a_inf && b_zero) || (b_inf && a_zero) ? QNAN :
                                 (a_inf || b_inf) ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                                    {sign, {(W-1){1'b0}}};
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_param.sv
// tb_fp_mult_param: directed-vector bench for fp_mult_param in binary32 and a 5/10 narrow format
module tb_fp_mult_param;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_in = '0, b_in = '0, c;
    logic        busy, done, ovf, unf, inv, inx;
    logic        start_h = 1'b0;
    logic [15:0] ah = '0, bh = '0, ch;
    logic        busy_h, done_h, ovf_h, unf_h, inv_h, inx_h;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fp_mult_param dut (
        .clk(clk), .reset(reset), .start(start), .A(a_in), .B(b_in), .C(c),
        .busy(busy), .done(done), .overflow(ovf), .underflow(unf), .invalid(inv), .inexact(inx)
    );

    fp_mult_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .start(start_h), .A(ah), .B(bh), .C(ch),
        .busy(busy_h), .done(done_h), .overflow(ovf_h), .underflow(unf_h), .invalid(inv_h), .inexact(inx_h)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags are compared as {overflow, underflow, invalid, inexact}
    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_c, input logic [3:0] exp_f, input int exp_lat);
        int   n;
        logic busy_ok;
        @(negedge clk);
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_c"}, c, exp_c);
        check({tag, "_flags"}, {28'd0, ovf, unf, inv, inx}, {28'd0, exp_f});
        @(posedge clk);
        #1 check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        #1;
        check("rst_c", c, 32'h0);
        check("rst_ctrl", {26'd0, busy, done, ovf, unf, inv, inx}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        run("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
        run("mul_tiny",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 27);
        run("mul_renorm",  32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 27);
        run("mul_sign",    32'hBF800000, 32'h40490FDB, 32'hC0490FDB, 4'b0000, 27);
        run("tie_up",      32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 27);
        run("tie_even",    32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 27);
        run("overflow",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b1001, 27);
        run("underflow",   32'h00800000, 32'h00800000, 32'h00000000, 4'b0101, 27);
        run("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010, 2);
        run("ninf_x_2",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2);
        run("snan_x_1",    32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 2);
        run("nzero_x_1",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2);
        run("daz_sub",     32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 2);

        // start pulsed mid-operation must not recapture operands
        @(negedge clk);
        a_in = 32'h3FC00000;
        b_in = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            if (n == 5) begin
                a_in = 32'h40400000;
                b_in = 32'h40400000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1 n++;
        end
        start = 1'b0;
        check("ignore_start_lat", n, 27);
        check("ignore_start_c", c, 32'h40400000);
        @(posedge clk);
        #1 check("ignore_start_idle", {31'd0, busy}, 32'd0);

        // reset mid-operation aborts with no done and clears the result
        @(negedge clk);
        a_in = 32'h3F800001;
        b_in = 32'h3F800001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_c", c, 32'h0);
        pulses = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_still_idle", {31'd0, busy}, 32'd0);

        // narrow format: 1.5 * 2.0 = 3.0
        @(negedge clk);
        ah = 16'h3E00;
        bh = 16'h4000;
        start_h = 1'b1;
        @(posedge clk);
        #1 start_h = 1'b0;
        n = 0;
        while (!done_h && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("half_lat", n, 14);
        check("half_c", {16'd0, ch}, 32'h4200);
        check("half_flags", {28'd0, ovf_h, unf_h, inv_h, inx_h}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mult_param.md
# fp_mult_param

Parametrised sequential IEEE-754-style floating-point multiplier, the next generation of the single-precision shift-add multiplier. Exponent and fraction widths are set by parameters, with binary32 as the default. It adds round-to-nearest-even, full special-operand handling (zero, infinity, NaN) and IEEE exception flags. It sits on the datapath behind a start/busy/done handshake and uses one shared significand adder, retiring one multiplier bit per cycle.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥4); significand is MAN_W+1 bits with hidden 1
- BIAS, 2^(EXP_W-1)-1, exponent bias (derived localparam, not overridable)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- A, B  in  1+EXP_W+MAN_W  operands {sign, exp, frac}; captured at the edge that accepts start
- C  out  1+EXP_W+MAN_W  result; held until next done
- busy  out  1  high from acceptance edge until the edge that asserts done
- done  out  1  one-cycle pulse, result and flags valid
- overflow, underflow, invalid, inexact  out  1 each  flags; updated with done, held until the next done

## Operation
- States: IDLE, UNPACK, MULT, NORM, ROUND, EXC.
- IDLE:
  - With start=1: latch A and B, set busy, go to UNPACK.
  - With start=0: stay in IDLE.
- UNPACK: classify each operand.
  - exp=0 is zero. Subnormal inputs are treated as ±0 (DAZ).
  - exp=all-ones with frac=0 is Inf. exp=all-ones with frac≠0 is NaN.
  - Any special class goes to EXC.
  - Otherwise: sign = sA^sB; e = eA+eB-BIAS, computed signed in EXP_W+2 bits. Initialise P=0, counter=0. Go to MULT.
- MULT: shift-add over MAN_W+1 iterations.
  - Each cycle: if multiplier LSB=1, add the multiplicand into the high half of the 2(MAN_W+1)-bit product, then shift right with carry-in.
  - After counter reaches MAN_W+1, go to NORM.
- NORM:
  - If product MSB=1: shift right 1 and e=e+1.
  - Extract the MAN_W+1 significand, guard bit G, and sticky S (OR of all lower bits).
- ROUND (round-to-nearest-even):
  - Increment when G & (S | lsb).
  - If the increment carries out: significand = 1.0, e=e+1.
  - inexact = G|S.
  - If e ≥ 2^EXP_W-1: C = ±Inf, overflow=1, inexact=1.
  - Else if e ≤ 0: C = ±0 (flush-to-zero, no subnormal output), underflow=1, inexact=1.
  - Else pack {sign, e[EXP_W-1:0], frac}.
  - Register C, flags, done=1. Clear busy. Go to IDLE.
- EXC:
  - NaN operand → canonical qNaN {0, all-ones, 1 followed by zeros}; invalid=0.
  - Inf×0 → canonical qNaN, invalid=1.
  - Inf×finite or Inf×Inf → Inf with sign = sA^sB.
  - 0×finite → zero with sign = sA^sB.
  - All other flags are 0. Register the result, done=1, go to IDLE.
- start while busy is ignored; operands are not re-captured.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk): state=IDLE, C=0, busy=0, done=0, all flags=0, counter=0, product=0.
- Latency is counted in rising edges from the edge that accepts start to the edge that asserts done:
  - finite nonzero operands: MAN_W+4 (27 for default widths)
  - special operands: 2
- done is high for exactly one cycle. start may be high in that same cycle; since state is IDLE, start is accepted at the next edge, giving back-to-back throughput of one result per MAN_W+5 cycles.
- Reset mid-operation aborts immediately:
  - no done pulse, C and flags cleared
  - start must be reasserted after reset deasserts

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2.0) → C=0x40400000, all flags 0, done exactly 27 edges after acceptance, busy high throughout.
- 0x3F800001 × 0x3F800001 → C=0x3F800002, inexact=1.
- 0x3FFFFFFF × 0x3F800001 (exercises renormalisation) → C=0x40000000, inexact=1.
- 0xBF800000 × 0x40490FDB → C=0xC0490FDB, inexact=0 (sign path).
- Exponent extremes:
  - 0x7F000000 × 0x7F000000 → C=0x7F800000, overflow=1, inexact=1.
  - 0x00800000 × 0x00800000 → C=0x00000000, underflow=1.
- Special operands, done after 2 edges each:
  - 0x7F800000 × 0x00000000 → C=0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → C=0xFF800000.
  - 0x7FA00000 × 1.0 → C=0x7FC00000, invalid=0.
- Handshake and reset:
  - Pulse start again at cycle 5 with different A/B → ignored; result matches the first operands.
  - Assert reset at cycle 10 → busy=0, done never pulses, C=0.
  - Re-run with EXP_W=5, MAN_W=10: 0x3E00×0x4000 → 0x4200, latency 14.
